// File: rtl/nn_pkg.sv
// Shared types and default constants for neural-network node datapaths.
package nn_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int ONE_Q  = 1 << FRAC_W;

    typedef enum logic [1:0] {
        ACT_ID   = 2'd0,
        ACT_RELU = 2'd1,
        ACT_STEP = 2'd2
    } act_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ACT,
        DONE
    } node_state_e;

endpackage

// File: rtl/nn_activation.sv
// Combinational activation: rescale a wide accumulator, apply the activation
// function, and saturate to DATA_W. Code 3 behaves as identity.
module nn_activation #(
    parameter int DATA_W = nn_pkg::DATA_W,
    parameter int FRAC_W = nn_pkg::FRAC_W,
    parameter int ACC_W  = 40
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  nn_pkg::act_e             act_q,
    output logic        [DATA_W-1:0] result
);
    import nn_pkg::*;

    localparam logic signed [ACC_W-1:0] MAX_V =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
    localparam logic signed [ACC_W-1:0] ONE_V = ACC_W'(1) << FRAC_W;

    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] activated;

    always_comb begin
        shifted   = acc >>> FRAC_W;
        activated = shifted;
        case (act_q)
            ACT_RELU: if (shifted[ACC_W-1]) activated = '0;
            ACT_STEP: activated = shifted[ACC_W-1] ? '0 : ONE_V;
            default:  activated = shifted;
        endcase
        if (activated > MAX_V) begin
            result = MAX_V[DATA_W-1:0];
        end else if (activated < MIN_V) begin
            result = MIN_V[DATA_W-1:0];
        end else begin
            result = activated[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/nn_node_mac.sv
// Fixed-point neuron: streamed MAC over N_INPUTS pairs, then activation.
// Optional bias input enabled by defining NODE_MAC_BIAS_EN.
module nn_node_mac #(
    parameter int DATA_W   = nn_pkg::DATA_W,
    parameter int FRAC_W   = nn_pkg::FRAC_W,
    parameter int N_INPUTS = 64,
    parameter int ACC_W    = 40
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [1:0]        act_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] coef,
    input  logic [DATA_W-1:0] in_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] node_out,
    output logic              busy
`ifdef NODE_MAC_BIAS_EN
    ,
    input  logic [DATA_W-1:0] bias
`endif
);
    import nn_pkg::*;

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    node_state_e state, state_next;

    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_init;
    logic signed [2*DATA_W-1:0] prod;
    logic [CNT_W-1:0]           cnt;
    act_e                       act_q;
    logic [DATA_W-1:0]          act_res;
    logic                       beat;
    logic                       start_ok;
    logic                       last_beat;
    logic                       xfer;

    assign beat      = in_valid & in_ready;
    assign start_ok  = start & (state == IDLE);
    assign last_beat = beat & (cnt == LAST);
    assign xfer      = out_valid & out_ready;
    assign busy      = (state != IDLE);
    assign prod      = $signed(coef) * $signed(in_val);

`ifdef NODE_MAC_BIAS_EN
    assign acc_init = ACC_W'($signed(bias)) <<< FRAC_W;
`else
    assign acc_init = '0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (last_beat) state_next = ACT;
            ACT:     state_next = DONE;
            DONE:    if (xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // in_ready is a flop so the upstream handshake has no comb path from state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc       <= '0;
            cnt       <= '0;
            act_q     <= ACT_ID;
            node_out  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            if (start_ok) begin
                acc   <= acc_init;
                cnt   <= '0;
                act_q <= act_e'(act_sel);
            end else if (beat) begin
                acc <= acc + ACC_W'(prod);
                cnt <= last_beat ? '0 : cnt + 1'b1;
            end
            in_ready <= (state_next == ACCUM);
            if (state == ACT) begin
                node_out  <= act_res;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    nn_activation #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_act (
        .acc    (acc),
        .act_q  (act_q),
        .result (act_res)
    );

endmodule
